// File: rtl/disparity_wta.sv
// disparity_wta: winner-take-all disparity selection over PASSES passes of 4 costs per pixel,
// keeping the running best per column in a line buffer and emitting winners on the last pass.
module disparity_wta #(
    parameter int LINE_WIDTH = 640,
    parameter int PASSES     = 16,
    parameter int COST_W     = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              line_start,
    input  logic              cost_valid,
    input  logic [COST_W-1:0] cost_0,
    input  logic [COST_W-1:0] cost_1,
    input  logic [COST_W-1:0] cost_2,
    input  logic [COST_W-1:0] cost_3,
    output logic              disp_valid,
    output logic [5:0]        disp_out,
    output logic [9:0]        disp_x,
    output logic              line_done,
    output logic              busy
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state;
    logic [9:0] pix_x;
    logic [3:0] pass;
    logic [COST_W+5:0] best_mem [LINE_WIDTH];
    logic [COST_W-1:0] min01, min23, lmin, old_cost;
    logic [1:0] k01, k23, lk;
    logic [5:0] old_idx, win_idx;
    logic take, beat, last_x, last_pass;
    // Strict less-than at every stage keeps ties on the lower disparity.
    always_comb begin
        k01 = cost_1 < cost_0 ? 2'd1 : 2'd0;
        min01 = cost_1 < cost_0 ? cost_1 : cost_0;
        k23 = cost_3 < cost_2 ? 2'd3 : 2'd2;
        min23 = cost_3 < cost_2 ? cost_3 : cost_2;
        lk = min23 < min01 ? k23 : k01;
        lmin = min23 < min01 ? min23 : min01;
        {old_cost, old_idx} = best_mem[pix_x];
        take = pass == 4'd0 || lmin < old_cost;
        win_idx = take ? {pass, lk} : old_idx;
        beat = state == ACCUM && cost_valid && !line_start;
        last_x = pix_x == 10'(LINE_WIDTH - 1);
        last_pass = pass == 4'(PASSES - 1);
    end
    assign busy = state == ACCUM;
    always_ff @(posedge clock) begin
        if (beat && !reset && take)
            best_mem[pix_x] <= {lmin, pass, lk};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pix_x <= '0;
            pass <= '0;
            disp_valid <= 1'b0;
            disp_out <= '0;
            disp_x <= '0;
            line_done <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            line_done <= 1'b0;
            if (line_start) begin
                state <= ACCUM;
                pix_x <= '0;
                pass <= '0;
            end else if (beat) begin
                if (last_pass) begin
                    disp_valid <= 1'b1;
                    disp_out <= win_idx;
                    disp_x <= pix_x;
                end
                pix_x <= last_x ? 10'd0 : pix_x + 10'd1;
                if (last_x && last_pass) begin
                    state <= IDLE;
                    pass <= '0;
                    line_done <= 1'b1;
                end else if (last_x)
                    pass <= pass + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_disparity_wta.sv
// tb_disparity_wta: scoreboard bench; expected winners are queued as last-pass beats are driven.
module tb_disparity_wta;
    localparam int LW = 640;
    localparam int NP = 16;
    logic clock = 0, reset = 1, line_start = 0, cost_valid = 0;
    logic [11:0] cost_0 = 0, cost_1 = 0, cost_2 = 0, cost_3 = 0;
    logic disp_valid, line_done, busy;
    logic [5:0] disp_out;
    logic [9:0] disp_x;
    typedef struct {int cyc; int x; int d;} exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0, n_chk = 0, n_pass = 0, n_done = 0;

    disparity_wta #(.LINE_WIDTH(LW), .PASSES(NP), .COST_W(12)) dut (
        .clock(clock), .reset(reset), .line_start(line_start), .cost_valid(cost_valid),
        .cost_0(cost_0), .cost_1(cost_1), .cost_2(cost_2), .cost_3(cost_3),
        .disp_valid(disp_valid), .disp_out(disp_out), .disp_x(disp_x),
        .line_done(line_done), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expv, cyc);
    endtask

    function automatic logic [11:0] cost_of(input int t, input int x, input int d);
        case (t)
            1: return d == 22 ? 12'd10 : 12'd100;
            2: return x == 7 ? ((d == 40 || d == 63) ? 12'd30 : 12'd200) : 12'd50;
            3: return d == 60 ? 12'd4094 : 12'd4095;
            default: return 12'((x * 131 + d * 977 + x * d * 7) % 4096);
        endcase
    endfunction

    function automatic int exp_disp(input int t, input int x);
        int b = 0;
        for (int d = 1; d < 64; d++)
            if (cost_of(t, x, d) < cost_of(t, x, b)) b = d;
        return b;
    endfunction

    task automatic drive(input bit ls, input bit cv, input bit rs, input logic [11:0] a, b, c, d);
        @(posedge clock);
        #1;
        line_start = ls;
        cost_valid = cv;
        reset = rs;
        cost_0 = a; cost_1 = b; cost_2 = c; cost_3 = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Stop point (stop_p, stop_x) either aborts with line_start or asserts reset.
    task automatic run_row(input int t, input int gap_max, input bit send_start,
                           input int stop_p, input int stop_x, input bit stop_rst);
        if (send_start) drive(1, 1, 0, 1, 1, 1, 1);
        for (int p = 0; p < NP; p++)
            for (int x = 0; x < LW; x++) begin
                if (p == stop_p && x == stop_x) begin
                    if (stop_rst) drive(0, 1, 1, 0, 0, 0, 0);
                    else drive(1, 1, 0, 0, 0, 0, 0);
                    return;
                end
                repeat ($urandom_range(gap_max, 0)) idle();
                drive(0, 1, 0, cost_of(t, x, 4*p), cost_of(t, x, 4*p+1),
                      cost_of(t, x, 4*p+2), cost_of(t, x, 4*p+3));
                if (p == NP - 1) sb.push_back('{cyc + 1, x, exp_disp(t, x)});
            end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missing_result_x", -1, sb[0].x);
            void'(sb.pop_front());
        end
        if (disp_valid) begin
            if (sb.size() == 0) check("spurious_valid", 1, 0);
            else begin
                e = sb.pop_front();
                check("disp_cycle", cyc, e.cyc);
                check("disp_x", int'(disp_x), e.x);
                check("disp_out", int'(disp_out), e.d);
            end
        end
        if (line_done) begin
            n_done++;
            check("done_with_valid", int'(disp_valid), 1);
            check("done_x", int'(disp_x), LW - 1);
        end
    end

    initial begin
        repeat (3) drive(0, 0, 1, 0, 0, 0, 0);
        idle();
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_valid", disp_valid, 0);
        check("rst_out", disp_out, 0);
        check("rst_x", disp_x, 0);
        check("rst_done", line_done, 0);
        repeat (5) drive(0, 1, 0, 0, 0, 0, 0);
        idle();
        @(negedge clock);
        check("idle_busy", busy, 0);
        // Single strong disparity 22
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clock);
        check("accum_busy", busy, 1);
        run_row(1, 0, 0, -1, 0, 0);
        repeat (3) idle();
        check("t1_done", n_done, 1);
        check("t1_busy", busy, 0);
        // Ties everywhere, pixel 7 tie between 40 and 63
        run_row(2, 0, 1, -1, 0, 0);
        repeat (3) idle();
        check("t2_done", n_done, 2);
        // Abort mid-row, then a clean row
        run_row(1, 0, 1, 3, 100, 0);
        run_row(4, 0, 0, -1, 0, 0);
        repeat (3) idle();
        check("t4_done", n_done, 3);
        check("t4_busy", busy, 0);
        // Reset mid last pass
        run_row(2, 0, 1, 15, 300, 1);
        idle();
        @(negedge clock);
        check("t5_busy", busy, 0);
        check("t5_valid", disp_valid, 0);
        repeat (20) drive(0, 1, 0, 0, 0, 0, 0);
        idle();
        @(negedge clock);
        check("t5_busy_after", busy, 0);
        check("t5_done", n_done, 3);
        // Gaps and near-max costs
        run_row(3, 3, 1, -1, 0, 0);
        repeat (3) idle();
        check("t6_done", n_done, 4);
        check("t6_busy", busy, 0);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
